// File: rtl/rb_simon_pkg.sv
// rtl/rb_simon_pkg.sv - shared widths, share-bus offsets and host FSM state for the SIMON host
package rb_simon_pkg;

  localparam int SHARE_W = 256;
  localparam int RES_W   = 128;
  localparam int NSHARE  = 3;
  localparam int DIN_W   = SHARE_W * NSHARE;
  localparam int RND_W   = SHARE_W * 2;

  localparam int A_LSB = 2 * SHARE_W;
  localparam int B_LSB = SHARE_W;
  localparam int C_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WAIT,
    ST_HOLD
  } host_state_e;

endpackage

// File: rtl/rb_share_split.sv
// rtl/rb_share_split.sv - splits a 256-bit word into three XOR shares on the Din bus
// RB_SIMON_HOST_MASK_EN selects masked shares; undefined gives A=in_data, B=C=0.
module rb_share_split
  import rb_simon_pkg::*;
(
  input  logic [SHARE_W-1:0] in_data,
  input  logic [RND_W-1:0]   rnd_in,
  output logic [DIN_W-1:0]   share_bus
);

  logic [SHARE_W-1:0] r1;
  logic [SHARE_W-1:0] r2;

`ifdef RB_SIMON_HOST_MASK_EN
  assign r1 = rnd_in[RND_W-1:SHARE_W];
  assign r2 = rnd_in[SHARE_W-1:0];
`else
  // Debug build: randomness is dropped so the wrapper sees the raw word.
  logic unused_rnd;
  assign unused_rnd = ^rnd_in;
  assign r1 = '0;
  assign r2 = '0;
`endif

  assign share_bus[A_LSB +: SHARE_W] = in_data ^ r1 ^ r2;
  assign share_bus[B_LSB +: SHARE_W] = r1;
  assign share_bus[C_LSB +: SHARE_W] = r2;

endmodule

// File: rtl/rb_simon_host.sv
// rtl/rb_simon_host.sv - host initiator: loads shares into the SIMON wrapper and captures its result
// Masking is controlled by RB_SIMON_HOST_MASK_EN inside rb_share_split.
module rb_simon_host
  import rb_simon_pkg::*;
#(
  parameter int TIMEOUT = 4096,
  parameter int CW      = $clog2(TIMEOUT + 1)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [SHARE_W-1:0] in_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [RND_W-1:0]   rnd_in,
  output logic [DIN_W-1:0]   Din,
  output logic               Drdy,
  output logic               EN,
  input  logic [RES_W-1:0]   Dout,
  input  logic               Dvld,
  output logic [RES_W-1:0]   res_data,
  output logic               res_err,
  output logic               res_valid,
  input  logic               res_ready
);

  host_state_e        state_q, state_d;
  logic [DIN_W-1:0]   din_q, din_d;
  logic               drdy_q, drdy_d;
  logic               en_q, en_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [RES_W-1:0]   res_data_q, res_data_d;
  logic               res_err_q, res_err_d;
  logic [DIN_W-1:0]   share_bus;

  rb_share_split u_split (
    .in_data   (in_data),
    .rnd_in    (rnd_in),
    .share_bus (share_bus)
  );

  always_comb begin
    state_d    = state_q;
    din_d      = din_q;
    drdy_d     = 1'b0;
    en_d       = en_q;
    cnt_d      = cnt_q;
    res_data_d = res_data_q;
    res_err_d  = res_err_q;
    case (state_q)
      ST_IDLE: begin
        en_d = 1'b0;
        if (in_valid) begin
          state_d = ST_LOAD;
          din_d   = share_bus;
          drdy_d  = 1'b1;
          en_d    = 1'b1;
          cnt_d   = '0;
        end
      end
      ST_LOAD: begin
        state_d = ST_WAIT;
        en_d    = 1'b1;
        cnt_d   = '0;
      end
      ST_WAIT: begin
        en_d = 1'b1;
        // Dvld is checked first so a pulse on the final timeout cycle still counts.
        if (Dvld) begin
          state_d    = ST_HOLD;
          res_data_d = Dout;
          res_err_d  = 1'b0;
          en_d       = 1'b0;
          din_d      = '0;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d    = ST_HOLD;
          res_data_d = '0;
          res_err_d  = 1'b1;
          en_d       = 1'b0;
          din_d      = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_HOLD: begin
        en_d = 1'b0;
        if (res_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      din_q      <= '0;
      drdy_q     <= 1'b0;
      en_q       <= 1'b0;
      cnt_q      <= '0;
      res_data_q <= '0;
      res_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      din_q      <= din_d;
      drdy_q     <= drdy_d;
      en_q       <= en_d;
      cnt_q      <= cnt_d;
      res_data_q <= res_data_d;
      res_err_q  <= res_err_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign res_valid = (state_q == ST_HOLD);
  assign Din       = din_q;
  assign Drdy      = drdy_q;
  assign EN        = en_q;
  assign res_data  = res_data_q;
  assign res_err   = res_err_q;

endmodule

// File: tb/tb_rb_simon_host.sv
// tb/tb_rb_simon_host.sv - directed bench for rb_simon_host (long-timeout and TIMEOUT=16 instances)
module tb_rb_simon_host;

  logic         CLK = 1'b0;
  logic         RST;
  logic [255:0] in_data;
  logic [511:0] rnd_in;
  logic [127:0] Dout;

  logic         in_valid, in_ready, Drdy, EN, Dvld, res_err, res_valid, res_ready;
  logic [767:0] Din;
  logic [127:0] res_data;

  logic         to_in_valid, to_in_ready, to_Drdy, to_EN, to_Dvld, to_res_err, to_res_valid, to_res_ready;
  logic [767:0] to_Din;
  logic [127:0] to_res_data;

  int n_checks = 0;
  int n_errors = 0;

`ifdef RB_SIMON_HOST_MASK_EN
  localparam logic [255:0] EXP_A = {{31{8'h99}}, 8'h98};
  localparam logic [255:0] EXP_B = {32{8'hA5}};
  localparam logic [255:0] EXP_C = {32{8'h3C}};
`else
  localparam logic [255:0] EXP_A = 256'h1;
  localparam logic [255:0] EXP_B = '0;
  localparam logic [255:0] EXP_C = '0;
`endif
  localparam logic [127:0] RES_GOOD = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F1E_2D3C;
  localparam logic [127:0] RES_EDGE = 128'hCAFE_F00D_1111_2222_3333_4444_5555_6666;

  rb_simon_host dut (
    .CLK(CLK), .RST(RST), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .rnd_in(rnd_in), .Din(Din), .Drdy(Drdy), .EN(EN), .Dout(Dout), .Dvld(Dvld),
    .res_data(res_data), .res_err(res_err), .res_valid(res_valid), .res_ready(res_ready)
  );

  rb_simon_host #(.TIMEOUT(16)) dut_to (
    .CLK(CLK), .RST(RST), .in_data(in_data), .in_valid(to_in_valid), .in_ready(to_in_ready),
    .rnd_in(rnd_in), .Din(to_Din), .Drdy(to_Drdy), .EN(to_EN), .Dout(Dout), .Dvld(to_Dvld),
    .res_data(to_res_data), .res_err(to_res_err), .res_valid(to_res_valid), .res_ready(to_res_ready)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [767:0] got, input logic [767:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    logic         bad;
    logic [127:0] held;
    int           n;

    RST = 1'b1;
    in_data = '0; rnd_in = '0; Dout = '0;
    in_valid = 0; Dvld = 0; res_ready = 0;
    to_in_valid = 0; to_Dvld = 0; to_res_ready = 0;

    tick();
    tick();
    check("rst_din", Din, '0);
    check("rst_drdy", Drdy, 1'b0);
    check("rst_en", EN, 1'b0);
    check("rst_res_data", res_data, '0);
    check("rst_res_err", res_err, 1'b0);
    check("rst_res_valid", res_valid, 1'b0);
    check("rst_to_res_valid", to_res_valid, 1'b0);
    RST = 1'b0;
    tick();
    check("idle_in_ready", in_ready, 1'b1);
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (Drdy !== 1'b0 || EN !== 1'b0) bad = 1'b1;
    end
    check("idle_no_drdy", bad, 1'b0);

    // Masked load and normal completion, Dvld 300 cycles after the Drdy cycle
    in_data = 256'h1;
    rnd_in = {{32{8'hA5}}, {32{8'h3C}}};
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_data = {64{4'hF}};
    check("load_drdy", Drdy, 1'b1);
    check("load_en", EN, 1'b1);
    check("load_in_ready", in_ready, 1'b0);
    check("load_share_a", Din[767:512], EXP_A);
    check("load_share_b", Din[511:256], EXP_B);
    check("load_share_c", Din[255:0], EXP_C);
    tick();
    check("wait_drdy_low", Drdy, 1'b0);
    check("wait_en", EN, 1'b1);
    bad = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 298; i++) begin
      if (Din !== {EXP_A, EXP_B, EXP_C} || Drdy !== 1'b0 || EN !== 1'b1 || res_valid !== 1'b0) bad = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    check("wait_stable", bad, 1'b0);
    Dvld = 1'b1;
    Dout = RES_GOOD;
    tick();
    Dvld = 1'b0;
    Dout = '0;
    check("done_res_valid", res_valid, 1'b1);
    check("done_res_data", res_data, RES_GOOD);
    check("done_res_err", res_err, 1'b0);
    check("done_din_wiped", Din, '0);
    check("done_en_low", EN, 1'b0);

    // Back-pressure
    bad = 1'b0;
    held = res_data;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (res_valid !== 1'b1 || res_data !== RES_GOOD || res_err !== 1'b0 || in_ready !== 1'b0) bad = 1'b1;
    end
    check("bp_stable", bad, 1'b0);
    check("bp_held", held, RES_GOOD);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("bp_release_valid", res_valid, 1'b0);
    check("bp_release_in_ready", in_ready, 1'b1);

    // Timeout: result on the 17th edge after the accept edge (accept cycle + 2 + TIMEOUT)
    check("to_in_ready", to_in_ready, 1'b1);
    to_in_valid = 1'b1;
    tick();
    to_in_valid = 1'b0;
    check("to_load_drdy", to_Drdy, 1'b1);
    check("to_load_en", to_EN, 1'b1);
    n = 0;
    while (n < 100 && to_res_valid !== 1'b1) begin
      tick();
      n++;
    end
    check("to_res_valid", to_res_valid, 1'b1);
    check("to_latency", n, 17);
    check("to_res_err", to_res_err, 1'b1);
    check("to_res_data", to_res_data, '0);
    check("to_din_wiped", to_Din, '0);
    to_res_ready = 1'b1;
    tick();
    to_res_ready = 1'b0;

    // Dvld on the final timeout cycle wins
    to_in_valid = 1'b1;
    tick();
    to_in_valid = 1'b0;
    for (int i = 0; i < 16; i++) tick();
    check("tie_not_early", to_res_valid, 1'b0);
    to_Dvld = 1'b1;
    Dout = RES_EDGE;
    tick();
    to_Dvld = 1'b0;
    Dout = '0;
    check("tie_res_valid", to_res_valid, 1'b1);
    check("tie_res_err", to_res_err, 1'b0);
    check("tie_res_data", to_res_data, RES_EDGE);
    to_res_ready = 1'b1;
    tick();
    to_res_ready = 1'b0;

    // Stale Dvld during LOAD is ignored, then reset in WAIT
    in_data = 256'h55;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    Dvld = 1'b1;
    Dout = RES_EDGE;
    tick();
    Dvld = 1'b0;
    Dout = '0;
    check("stale_no_result", res_valid, 1'b0);
    check("stale_en", EN, 1'b1);
    tick();
    tick();
    check("stale_still_wait", res_valid, 1'b0);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("rstwait_en", EN, 1'b0);
    check("rstwait_din", Din, '0);
    check("rstwait_in_ready", in_ready, 1'b1);
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (res_valid !== 1'b0 || EN !== 1'b0) bad = 1'b1;
    end
    check("rstwait_no_result", bad, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rb_simon_host.md
# rb_simon_host

Host-side initiator for the bit-serial masked SIMON wrapper. It accepts a 256-bit plaintext/key word from an upstream valid/ready source and splits it into three 256-bit shares. It drives the wrapper's parallel load interface (Din/Drdy/EN), waits for the wrapper's one-cycle Dvld, and captures the 128-bit result. The result is held for a downstream valid/ready sink. It sits between the test/stimulus fabric and the wrapper, which serializes shares into the core.

## Interface
Parameters:
- TIMEOUT, 4096, cycles spent in WAIT without Dvld before aborting; must be ≥ 2
- CW, $clog2(TIMEOUT+1), timeout counter width (derived)

Ports:
- CLK  in  1  system clock, the only clock
- RST  in  1  reset, synchronous, active-high
- in_data  in  256  plaintext/key word, [255:128] key, [127:0] plaintext
- in_valid  in  1  upstream word valid
- in_ready  out  1  block can accept a word
- rnd_in  in  512  fresh mask bits, sampled on accept; r1=[511:256], r2=[255:0]
- Din  out  768  share bus to wrapper: [767:512] A, [511:256] B, [255:0] C
- Drdy  out  1  load strobe to wrapper
- EN  out  1  wrapper enable
- Dout  in  128  wrapper result
- Dvld  in  1  wrapper result valid, one-cycle pulse
- res_data  out  128  captured result
- res_err  out  1  result aborted by timeout
- res_valid  out  1  result available
- res_ready  in  1  downstream accepts result

## Operation
- FSM states: IDLE, LOAD, WAIT, HOLD.
- IDLE
  - in_ready=1, EN=0, Drdy=0.
  - On in_valid & in_ready: register the shares, go to LOAD.
- LOAD (exactly 1 cycle)
  - Drdy=1, EN=1, timeout counter cleared.
  - Go to WAIT.
- WAIT
  - Drdy=0, EN=1, counter increments each cycle.
  - Dvld=1: res_data<=Dout, res_err<=0, go to HOLD.
  - Otherwise, counter==TIMEOUT-1: res_data<=0, res_err<=1, go to HOLD.
- HOLD
  - EN=0, res_valid=1.
  - On res_ready: go to IDLE.
- Share split, all XOR on 256 bits: A = in_data ^ r1 ^ r2, B = r1, C = r2.
- Din is held stable from LOAD through WAIT. It is cleared to all-zero on the edge entering HOLD (share wipe).
- Dvld is ignored in every state other than WAIT. This covers a stale pulse during LOAD.
- If Dvld and the timeout condition occur in the same cycle, Dvld wins: good result, res_err=0.
- A new in_valid is not accepted in any state except IDLE. There is no back-to-back overlap.

## Timing
- Reset, on the first CLK edge with RST=1:
  - state=IDLE
  - Din=0, Drdy=0, EN=0
  - res_data=0, res_err=0, res_valid=0
  - counter=0
  - in_ready=1 from the next cycle.
- RST mid-operation has the same effect as reset. EN drops the next cycle, which freezes the wrapper. No result is emitted.
- Accept edge → LOAD cycle (Drdy high) → WAIT from the following edge.
- Latency from accept to res_valid is 2 + N cycles, where N is the number of WAIT cycles until Dvld inclusive.
- Timeout latency is exactly 2 + TIMEOUT cycles.
- res_valid/res_data/res_err are stable while res_valid=1 and res_ready=0.
- res_valid falls on the edge after the cycle with res_ready=1.
- in_ready rises in that same cycle.
- Outputs are registered except in_ready and res_valid, which are decoded from state.

## Configuration
- Macro: RB_SIMON_HOST_MASK_EN.
- Defined: shares use rnd_in as above.
- Undefined: r1=r2=0, so A=in_data and B=C=0. rnd_in is unused. This is an unmasked debug mode for functional comparison against the reference cipher.

## Structure
- Package rb_simon_pkg holds:
  - share-width constants: SHARE_W=256, RES_W=128, NSHARE=3
  - the host FSM state enum typedef
  - the Din slice offset constants.
- Sub-module rb_share_split is natural: the combinational split of in_data and rnd_in into the 768-bit share bus, including the macro handling.
- The FSM, counter and registers stay in rb_simon_host.

## Test plan
- Reset then idle: hold RST 2 cycles.
  - All outputs are 0, and in_ready=1 after release.
  - No Drdy while in_valid=0.
- Masked load (macro on): in_data=256'h1, rnd_in={256'hA5…A5, 256'h3C…3C}.
  - Din[767:512] = 1^A5..^3C.., Din[511:256] = A5.., Din[255:0] = 3C...
  - Drdy is high exactly 1 cycle, and EN is high.
- Normal completion: model Dvld pulse 300 cycles after Drdy with Dout=128'hDEAD_BEEF_….
  - res_valid=1 with that data and res_err=0.
  - Din=0 in HOLD.
- Back-pressure: hold res_ready=0 for 10 cycles.
  - Result stable, in_ready=0.
  - Raise res_ready → IDLE the next cycle.
- Timeout: TIMEOUT=16, never pulse Dvld.
  - res_valid exactly 18 cycles after accept, with res_err=1 and res_data=0.
- Corner cases:
  - Dvld pulse during LOAD is ignored.
  - Dvld coinciding with the timeout cycle gives res_err=0.
  - RST asserted in WAIT gives EN=0 next cycle and no res_valid.
